load_store_unit: RTL and testbench

//  Sits between the core (ALU address, register-file store data) and datamem. It turns byte, halfword
//  and word load/store requests into word-indexed datamem accesses (enable, readwrite, Ina, Inb,

---
 rtl/load_store_unit.sv | 139 +++++++++++++
 tb/tb_load_store_unit.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Load/store unit between the core and datamem: word-indexed accesses, lane extraction with
// sign/zero extension, read-modify-write for sub-word stores, and fault reporting.
module load_store_unit #(
    parameter int ADDR_W  = 16,
    parameter int MEM_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_fault,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_enable,
    output logic        mem_rw,
    input  logic [31:0] mem_rdata
);
    localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    typedef enum logic [2:0] {IDLE, RD, WAIT, WR, RESP} state_t;

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt;
    logic             accept, acc_fault, last_wait;
    logic             write_q, signed_q, fault_q;
    logic [1:0]       size_q, lane_q;
    logic [15:0]      wdata_q;
    logic [31:0]      rdata_q;

    function automatic logic [31:0] extend_lane(input logic [31:0] word, input logic [1:0] size,
                                                input logic [1:0] lane, input logic sgn);
        logic signed [7:0]  b;
        logic signed [15:0] h;
        logic [31:0]        r;
        b = word[{lane, 3'b000} +: 8];
        h = word[{lane[1], 4'b0000} +: 16];
        case (size)
            2'b00:   r = sgn ? {{24{b[7]}}, b} : {24'd0, b};
            2'b01:   r = sgn ? {{16{h[15]}}, h} : {16'd0, h};
            default: r = word;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] merge_lane(input logic [31:0] word, input logic [15:0] data,
                                               input logic [1:0] size, input logic [1:0] lane);
        logic [31:0] r;
        r = word;
        if (size == 2'b00) r[{lane, 3'b000} +: 8] = data[7:0];
        else               r[{lane[1], 4'b0000} +: 16] = data;
        return r;
    endfunction

    assign accept    = req_valid && (state == IDLE);
    assign acc_fault = (req_size == 2'b11) ||
                       (req_size == 2'b01 && req_addr[0]) ||
                       (req_size == 2'b10 && req_addr[1:0] != 2'b00) ||
                       (req_addr[31:ADDR_W+2] != '0);
    assign last_wait = (state == WAIT) && (cnt == '0);

    always_comb begin
        state_nx   = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        resp_rdata = '0;
        resp_fault = 1'b0;
        mem_enable = 1'b0;
        mem_rw     = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (acc_fault)                           state_nx = RESP;
                    else if (req_write && req_size == 2'b10) state_nx = WR;
                    else                                     state_nx = RD;
                end
            end
            RD: begin
                mem_enable = 1'b1;
                state_nx   = WAIT;
            end
            WAIT: begin
                if (cnt == '0) state_nx = write_q ? WR : RESP;
            end
            WR: begin
                mem_enable = 1'b1;
                mem_rw     = 1'b1;
                state_nx   = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                resp_rdata = rdata_q;
                resp_fault = fault_q;
                state_nx   = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Control and datamem-facing registers; all of these are visible outputs and clear on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            state <= state_nx;
            if (state == RD)                  cnt <= CNT_W'(MEM_LAT - 1);
            else if (state == WAIT && cnt != '0) cnt <= cnt - CNT_W'(1);
            if (accept && !acc_fault) begin
                mem_addr <= {{(32-ADDR_W){1'b0}}, req_addr[ADDR_W+1:2]};
                if (req_write && req_size == 2'b10) mem_wdata <= req_wdata;
            end
            if (last_wait && write_q) mem_wdata <= merge_lane(mem_rdata, wdata_q, size_q, lane_q);
        end
    end

    // Latched request fields; only observed through state-gated outputs, so no reset needed.
    always_ff @(posedge clk) begin
        if (accept) begin
            write_q  <= req_write;
            signed_q <= req_signed;
            size_q   <= req_size;
            lane_q   <= req_addr[1:0];
            wdata_q  <= req_wdata[15:0];
            fault_q  <= acc_fault;
            rdata_q  <= '0;
        end
        if (last_wait && !write_q) rdata_q <= extend_lane(mem_rdata, size_q, lane_q, signed_q);
    end
endmodule

// File: tb/tb_load_store_unit.sv
// Testbench for load_store_unit: two instances (MEM_LAT 1 and 3), each with a datamem model,
// driven by request tasks that push expected responses into a shared scoreboard queue.
module tb_load_store_unit;
    typedef struct {
        int          inst;
        logic [31:0] rdata;
        logic        fault;
        int          lat;
        logic        has_wr;
        int          wr_cyc;
        logic [31:0] wr_addr;
        logic [31:0] wr_data;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic [1:0]       req_valid, req_ready, req_write, req_signed;
    logic [1:0]       resp_valid, resp_fault, mem_enable, mem_rw;
    logic [1:0][1:0]  req_size;
    logic [1:0][31:0] req_addr, req_wdata, resp_rdata, mem_addr, mem_wdata, mem_rdata;
    logic [1:0]       b2b_chk;
    logic [31:0]      shadow [2][256];
    exp_t             sb_q[$];
    int               n_checks = 0;
    int               n_errors = 0;
    int               cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : gen_u
        localparam int LAT = 2 * g + 1;
        logic [31:0] mem  [256];
        logic [31:0] pipe [LAT];
        int          acc, wr_cyc, last_resp;
        bit          saw_en, saw_wr;
        logic [31:0] wr_a, wr_d;
        exp_t        e;

        load_store_unit #(.ADDR_W(16), .MEM_LAT(LAT)) dut (
            .clk        (clk),
            .rst        (rst),
            .req_valid  (req_valid[g]),
            .req_ready  (req_ready[g]),
            .req_write  (req_write[g]),
            .req_size   (req_size[g]),
            .req_signed (req_signed[g]),
            .req_addr   (req_addr[g]),
            .req_wdata  (req_wdata[g]),
            .resp_valid (resp_valid[g]),
            .resp_rdata (resp_rdata[g]),
            .resp_fault (resp_fault[g]),
            .mem_addr   (mem_addr[g]),
            .mem_wdata  (mem_wdata[g]),
            .mem_enable (mem_enable[g]),
            .mem_rw     (mem_rw[g]),
            .mem_rdata  (mem_rdata[g])
        );

        // datamem model: read data appears LAT cycles after the strobe, poison otherwise
        always @(posedge clk) begin
            if (mem_enable[g] && mem_rw[g]) mem[mem_addr[g][7:0]] <= mem_wdata[g];
            pipe[0] <= (mem_enable[g] && !mem_rw[g]) ? mem[mem_addr[g][7:0]] : 32'hA5A5_A5A5;
            for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
        end
        assign mem_rdata[g] = pipe[LAT-1];

        always @(negedge clk) begin
            if (rst) begin
                saw_en = 1'b0;
                saw_wr = 1'b0;
            end else begin
                if (!mem_enable[g]) chk($sformatf("u%0d rw_without_enable", g), {31'd0, mem_rw[g]}, 32'd0);
                if (mem_enable[g]) begin
                    saw_en = 1'b1;
                    if (mem_rw[g]) begin
                        saw_wr = 1'b1;
                        wr_a   = mem_addr[g];
                        wr_d   = mem_wdata[g];
                        wr_cyc = cyc - acc;
                    end
                end
                if (resp_valid[g]) begin
                    if (sb_q.size() == 0 || sb_q[0].inst != g) begin
                        chk($sformatf("u%0d unexpected_resp", g), {31'd0, resp_valid[g]}, 32'd0);
                    end else begin
                        e = sb_q.pop_front();
                        chk($sformatf("u%0d rdata", g), resp_rdata[g], e.rdata);
                        chk($sformatf("u%0d fault", g), {31'd0, resp_fault[g]}, {31'd0, e.fault});
                        chk($sformatf("u%0d resp_cycle", g), cyc - acc, e.lat);
                        chk($sformatf("u%0d mem_touched", g), {31'd0, saw_en}, {31'd0, ~e.fault});
                        chk($sformatf("u%0d write_issued", g), {31'd0, saw_wr}, {31'd0, e.has_wr});
                        if (e.has_wr) begin
                            chk($sformatf("u%0d wr_addr", g), wr_a, e.wr_addr);
                            chk($sformatf("u%0d wr_data", g), wr_d, e.wr_data);
                            chk($sformatf("u%0d wr_cycle", g), wr_cyc, e.wr_cyc);
                        end
                    end
                    last_resp = cyc;
                end else begin
                    chk($sformatf("u%0d rdata_idle", g), resp_rdata[g] | {31'd0, resp_fault[g]}, 32'd0);
                end
                if (req_valid[g] && req_ready[g]) begin
                    if (b2b_chk[g]) chk($sformatf("u%0d b2b_gap", g), cyc - last_resp, 32'd1);
                    acc    = cyc;
                    saw_en = 1'b0;
                    saw_wr = 1'b0;
                end
            end
        end
    end

    task automatic issue(input int u, input bit wr, input logic [1:0] sz, input bit sg,
                         input logic [31:0] a, input logic [31:0] wd, input bit track, input bit hold);
        exp_t        e;
        logic [31:0] w, t, nw;
        int          bsh, hsh, lat, n;
        bsh = 8 * int'(a[1:0]);
        hsh = 16 * int'(a[1]);
        lat = 2 * u + 1;
        w   = shadow[u][a[9:2]];
        e.inst  = u;
        e.fault = (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00) ||
                  (a[31:18] != 14'd0);
        case (sz)
            2'b00: begin
                t = (w >> bsh) & 32'hFF;
                if (sg && t[7]) t = t | 32'hFFFF_FF00;
                nw = (w & ~(32'hFF << bsh)) | ((wd & 32'hFF) << bsh);
            end
            2'b01: begin
                t = (w >> hsh) & 32'hFFFF;
                if (sg && t[15]) t = t | 32'hFFFF_0000;
                nw = (w & ~(32'hFFFF << hsh)) | ((wd & 32'hFFFF) << hsh);
            end
            default: begin
                t  = w;
                nw = wd;
            end
        endcase
        e.rdata   = (!wr && !e.fault) ? t : 32'd0;
        e.has_wr  = wr && !e.fault;
        e.wr_addr = a >> 2;
        e.wr_data = nw;
        e.wr_cyc  = (sz == 2'b10) ? 1 : 2 + lat;
        if (e.fault)           e.lat = 1;
        else if (!wr)          e.lat = 2 + lat;
        else if (sz == 2'b10)  e.lat = 2;
        else                   e.lat = 3 + lat;
        req_write[u]  = wr;
        req_size[u]   = sz;
        req_signed[u] = sg;
        req_addr[u]   = a;
        req_wdata[u]  = wd;
        req_valid[u]  = 1'b1;
        n = 0;
        while (!req_ready[u] && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 100) begin
            chk("accept_timeout", {31'd0, req_ready[u]}, 32'd1);
        end else begin
            sb_q.push_back(e);
            if (track && e.has_wr) shadow[u][a[9:2]] = nw;
            @(posedge clk); #1;
        end
        if (!hold) req_valid[u] = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb_q.size() != 0 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain_pending", sb_q.size(), 32'd0);
        sb_q.delete();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        req_valid = '0; req_write = '0; req_signed = '0; req_size = '0;
        req_addr  = '0; req_wdata = '0; b2b_chk = '0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        for (int u = 0; u < 2; u++) begin
            chk("rst_ready", {31'd0, req_ready[u]}, 32'd1);
            chk("rst_outs", {28'd0, resp_valid[u], resp_fault[u], mem_enable[u], mem_rw[u]}, 32'd0);
            chk("rst_data", resp_rdata[u] | mem_addr[u] | mem_wdata[u], 32'd0);
        end
        rst = 1'b0;
        @(posedge clk); #1;

        for (int w = 0; w < 16; w++)
            for (int u = 0; u < 2; u++) begin
                issue(u, 1'b1, 2'b10, 1'b0, w * 4, $urandom, 1'b1, 1'b0);
                drain();
            end

        // word store, then the four loads over it, then a byte read-modify-write
        issue(0, 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF, 1'b1, 1'b0); drain();
        issue(0, 1'b0, 2'b00, 1'b1, 32'h11, 32'h0, 1'b1, 1'b0); drain();
        issue(0, 1'b0, 2'b00, 1'b0, 32'h11, 32'h0, 1'b1, 1'b0); drain();
        issue(0, 1'b0, 2'b01, 1'b1, 32'h12, 32'h0, 1'b1, 1'b0); drain();
        issue(0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b1, 1'b0); drain();
        issue(0, 1'b1, 2'b00, 1'b0, 32'h13, 32'h55, 1'b1, 1'b0); drain();
        issue(0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b1, 1'b0); drain();
        issue(1, 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF, 1'b1, 1'b0); drain();
        issue(1, 1'b1, 2'b00, 1'b0, 32'h13, 32'h55, 1'b1, 1'b0); drain();
        issue(1, 1'b1, 2'b01, 1'b0, 32'h22, 32'hFFFF_8001, 1'b1, 1'b0); drain();
        issue(1, 1'b0, 2'b01, 1'b0, 32'h22, 32'h0, 1'b1, 1'b0); drain();

        // faults
        issue(0, 1'b0, 2'b10, 1'b0, 32'h06, 32'h0, 1'b1, 1'b0); drain();
        issue(0, 1'b0, 2'b11, 1'b0, 32'h20, 32'h0, 1'b1, 1'b0); drain();
        issue(0, 1'b1, 2'b01, 1'b0, 32'h01, 32'h1234, 1'b1, 1'b0); drain();
        issue(0, 1'b0, 2'b10, 1'b0, 32'h0004_0000, 32'h0, 1'b1, 1'b0); drain();
        issue(0, 1'b1, 2'b10, 1'b0, 32'h0004_0010, 32'h1111_2222, 1'b1, 1'b0); drain();

        // reset while an sb is waiting on its read
        issue(1, 1'b1, 2'b00, 1'b0, 32'h10, 32'h77, 1'b0, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("midrst_ready", {31'd0, req_ready[1]}, 32'd1);
        chk("midrst_outs", {28'd0, resp_valid[1], resp_fault[1], mem_enable[1], mem_rw[1]}, 32'd0);
        chk("midrst_data", resp_rdata[1] | mem_addr[1] | mem_wdata[1], 32'd0);
        sb_q.delete();
        @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        issue(1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b1, 1'b0); drain();

        // back-to-back with req_valid held; second request's fields change while the first is busy
        issue(0, 1'b0, 2'b10, 1'b0, 32'h08, 32'h0, 1'b1, 1'b1);
        b2b_chk[0] = 1'b1;
        issue(0, 1'b1, 2'b10, 1'b0, 32'h0C, 32'hCAFE_F00D, 1'b1, 1'b0);
        b2b_chk[0] = 1'b0;
        drain();
        issue(0, 1'b0, 2'b10, 1'b0, 32'h0C, 32'h0, 1'b1, 1'b0); drain();

        for (int i = 0; i < 40; i++) begin
            logic [31:0] a;
            a = $urandom_range(0, 63);
            if ($urandom_range(0, 7) == 0) a = a | 32'h0004_0000;
            issue(i % 2, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  a, $urandom, 1'b1, 1'b0);
            drain();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
